// File: rtl/vga_out.sv
// VGA timing generator with a top-left image window: pixel tick from a clk/4 divider,
// sequential image read address, and one-tick colour/sync alignment for a 1-clk-latency source.
module vga_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        r,
  input  logic [3:0]        g,
  input  logic [3:0]        b,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_valid,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_IMG  = HW'(IMG_W);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_IMG  = VW'(IMG_H);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [1:0]    r_div;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          r_act;
  logic          r_hs_cur;
  logic          r_vs_cur;

  logic w_tick, w_active, w_window, w_hs_n, w_vs_n, w_first, w_h_wrap;

  assign w_tick   = (r_div == 2'd3);
  assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_window = (r_h < H_IMG) && (r_v < V_IMG);
  assign w_hs_n   = !((r_h >= H_SS) && (r_h < H_SE));
  assign w_vs_n   = !((r_v >= V_SS) && (r_v < V_SE));
  assign w_first  = (r_h == '0) && (r_v == '0);
  assign w_h_wrap = (r_h == H_LAST);

  // r_h/r_v name the pixel being presented on this tick; pix_valid/r_act then
  // describe it during the following tick, when its memory data arrives on r/g/b.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div       <= '0;
      r_h         <= '0;
      r_v         <= '0;
      r_act       <= 1'b0;
      r_hs_cur    <= 1'b1;
      r_vs_cur    <= 1'b1;
      pix_addr    <= '0;
      pix_valid   <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      r_div       <= r_div + 2'd1;
      frame_start <= w_tick && w_first;
      if (w_tick) begin
        r_h <= w_h_wrap ? '0 : r_h + HW'(1);
        if (w_h_wrap)
          r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
        pix_valid <= w_window;
        r_act     <= w_active;
        if (w_first)
          pix_addr <= '0;
        else if (w_window)
          pix_addr <= pix_addr + ADDR_W'(1);
        if (pix_valid && r_act)
          {vga_r, vga_g, vga_b} <= {r, g, b};
        else
          {vga_r, vga_g, vga_b} <= '0;
        // Sync goes through the same one-tick delay as colour.
        r_hs_cur <= w_hs_n;
        r_vs_cur <= w_vs_n;
        hsync    <= r_hs_cur;
        vsync    <= r_vs_cur;
      end
    end
  end
endmodule

// File: tb/tb_vga_out.sv
// Randomized bench for vga_out on a shrunken timing (24x13 frame, 6x5 image) so that
// several frames fit in a short run; outputs compared every clk against a pixel-index model.
module tb_vga_out;
  localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 8,  V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam int IMG_W = 6, IMG_H = 5, ADDR_W = 15;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] r = '0, g = '0, b = '0;
  logic [ADDR_W-1:0] pix_addr;
  logic pix_valid, hsync, vsync, frame_start;
  logic [3:0] vga_r, vga_g, vga_b;

  vga_out #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .r(r), .g(g), .b(b),
    .pix_addr(pix_addr), .pix_valid(pix_valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit win(input int h, input int v);
    return (h < IMG_W) && (v < IMG_H);
  endfunction

  // Address presented for pixel (h,v): window pixels count up row-major; outside the
  // window the last window address of the frame so far is held.
  function automatic int addr_of(input int h, input int v);
    if (v >= IMG_H) return IMG_W * IMG_H - 1;
    if (h >= IMG_W) return v * IMG_W + IMG_W - 1;
    return v * IMG_W + h;
  endfunction

  function automatic bit hs_low(input int h);
    return (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
  endfunction

  function automatic bit vs_low(input int v);
    return (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
  endfunction

  // Model: tick n after reset release shows pixel n mod FT; colour/sync describe pixel n-1.
  int m_clk, m_n;
  int e_addr, e_h, e_v;
  logic e_valid, e_hs, e_vs, e_fs;
  logic [11:0] e_rgb;

  always @(posedge clk or posedge rst) begin : model
    int p, h, v, pp, ph, pv;
    bit first;
    if (rst) begin
      m_clk <= 0; m_n <= 0;
      e_addr <= 0; e_valid <= 1'b0; e_rgb <= '0;
      e_hs <= 1'b1; e_vs <= 1'b1; e_fs <= 1'b0;
      e_h <= -1; e_v <= -1;
    end else begin
      m_clk <= m_clk + 1;
      e_fs  <= 1'b0;
      if ((m_clk + 1) % 4 == 0) begin
        p  = m_n % FT;  h  = p % HT;  v  = p / HT;
        pp = (p + FT - 1) % FT; ph = pp % HT; pv = pp / HT;
        first = (m_n == 0);
        e_h     <= h;
        e_v     <= v;
        e_valid <= win(h, v);
        e_addr  <= addr_of(h, v);
        e_rgb   <= (!first && win(ph, pv)) ? {r, g, b} : 12'h000;
        e_hs    <= (!first && hs_low(ph)) ? 1'b0 : 1'b1;
        e_vs    <= (!first && vs_low(pv)) ? 1'b0 : 1'b1;
        e_fs    <= (p == 0);
        m_n     <= m_n + 1;
      end
    end
  end

  bit started = 0;
  bit fs_seen = 0;
  int clk_abs = 0, fs_clk = 0, hs_lo = 0, vs_lo = 0;

  always @(negedge clk) begin
    clk_abs++;
    if (started) begin
      chk("pix_addr",    int'(pix_addr), e_addr);
      chk("pix_valid",   int'(pix_valid), int'(e_valid));
      chk("vga_rgb",     int'({vga_r, vga_g, vga_b}), int'(e_rgb));
      chk("hsync",       int'(hsync), int'(e_hs));
      chk("vsync",       int'(vsync), int'(e_vs));
      chk("frame_start", int'(frame_start), int'(e_fs));
      if (!rst) begin
        if (e_h == 0 && e_v == 1)  chk("addr_line1_start", int'(pix_addr), 6);
        if (e_h == 5 && e_v == 4)  chk("addr_last_window", int'(pix_addr), 29);
        if (e_h == 20 && e_v == 12) chk("addr_held_blank", int'(pix_addr), 29);
        if (e_h == 6 && e_v == 0)  chk("valid_right_edge", int'(pix_valid), 0);
      end
      if (rst) begin
        fs_seen = 0;
      end else begin
        if (frame_start) begin
          if (fs_seen) begin
            chk("frame_spacing_clk", clk_abs - fs_clk, 1248);
            chk("hsync_low_clk_per_frame", hs_lo, 156);
            chk("vsync_low_clk_per_frame", vs_lo, 192);
          end
          fs_seen = 1; fs_clk = clk_abs; hs_lo = 0; vs_lo = 0;
        end
        if (!hsync) hs_lo++;
        if (!vsync) vs_lo++;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  int'(pix_addr), 0);
    chk({tag, "_valid"}, int'(pix_valid), 0);
    chk({tag, "_rgb"},   int'({vga_r, vga_g, vga_b}), 0);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_fs"},    int'(frame_start), 0);
  endtask

  // mode 0: constant A, 1: constant F, 2: random
  task automatic drive(input int mode, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      case (mode)
        0: begin r = 4'hA; g = 4'hA; b = 4'hA; end
        1: begin r = 4'hF; g = 4'hF; b = 4'hF; end
        default: begin r = 4'($urandom); g = 4'($urandom); b = 4'($urandom); end
      endcase
    end
  endtask

  initial begin
    bit hit;
    #1 rst = 1'b1;
    r = 4'h5; g = 4'h6; b = 4'h7;
    #1 chk_reset_vals("por");
    started = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(0, 1300);
    drive(1, 1300);
    drive(2, 2600);

    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      r = 4'($urandom); g = 4'($urandom); b = 4'($urandom);
      if (e_h == 12 && e_v == 6) hit = 1;
    end
    chk("reach_midframe_pixel", int'(hit), 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("mid");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(2, 2600);
    drive(1, 1300);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
